// File: rtl/mux_sweep_pkg.sv
// Shared types, sizes and the reference mux function for the mux sweep checker.
package mux_sweep_pkg;

   localparam int VEC_W   = 3;
   localparam int NUM_VEC = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic mux2_ref(input logic a, input logic b, input logic c);
      return c ? b : a;
   endfunction

endpackage

// File: rtl/mux_sweep_checker_settle_timer.sv
// Loadable down-counter that stops at zero and flags it; paces the per-vector hold.
module settle_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q, count_d;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/mux_sweep_checker.sv
// Drives all eight {a,b,c} vectors into an external 2:1 mux, samples z after a
// settle time per vector, and reports error count and first failing vector.
module mux_sweep_checker
   import mux_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       z,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic       fail_valid,
   output logic [2:0] fail_vec
);

   localparam int                 CNT_W    = 4;
   localparam logic [CNT_W-1:0]   RELOAD   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0]   LAST_IDX = VEC_W'(NUM_VEC - 1);

   state_e           state_q, state_d;
   logic [VEC_W-1:0] idx_q, idx_d;
   logic [3:0]       err_count_q, err_count_d;
   logic             fail_valid_q, fail_valid_d;
   logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
   logic             pass_q, pass_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic tmr_load, tmr_dec, tmr_zero;
   logic mismatch;

   settle_timer #(.W(CNT_W)) u_settle (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_value (RELOAD),
      .dec        (tmr_dec),
      .zero       (tmr_zero)
   );

   // z arrives straight from the combinational mux fed by idx_q.
   assign mismatch = (z != mux2_ref(idx_q[2], idx_q[1], idx_q[0]));

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      err_count_d  = err_count_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      pass_d       = pass_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      tmr_load     = 1'b0;
      tmr_dec      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d        = '0;
               tmr_load     = 1'b1;
               err_count_d  = '0;
               fail_valid_d = 1'b0;
               fail_vec_d   = '0;
               pass_d       = 1'b0;
               busy_d       = 1'b1;
               state_d      = RUN;
            end
         end
         RUN: begin
            if (!tmr_zero) begin
               tmr_dec = 1'b1;
            end else begin
               if (mismatch) begin
                  err_count_d = err_count_q + 4'd1;
                  if (!fail_valid_q) begin
                     fail_vec_d   = idx_q;
                     fail_valid_d = 1'b1;
                  end
               end
               if (idx_q != LAST_IDX) begin
                  idx_d    = idx_q + 1'b1;
                  tmr_load = 1'b1;
               end else begin
                  // Verdict includes the last vector's result, hence err_count_d.
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_count_d == 4'd0);
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         err_count_q  <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
         pass_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         err_count_q  <= err_count_d;
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
         pass_q       <= pass_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign a          = idx_q[2];
   assign b          = idx_q[1];
   assign c          = idx_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_count_q;
   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: three instances (S=2,1,15) each driving a modelled
// mux that can be golden, stuck at 0 or inverted; scoreboard queues hold expectations.
module tb_mux_sweep_checker;
   import mux_sweep_pkg::*;

   localparam int S_TAB [3] = '{2, 1, 15};
   localparam int M_GOLD = 0;
   localparam int M_ZERO = 1;
   localparam int M_INV  = 2;

   typedef struct {
      logic [3:0] err;
      logic       fv;
      logic [2:0] fvec;
      logic       pass;
   } status_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] start_v, a_v, b_v, c_v, z_v, busy_v, done_v, pass_v, fval_v;
   logic [3:0] err_v  [3];
   logic [2:0] fvec_v [3];
   int         mode   [3] = '{default: 0};

   int checks = 0;
   int errors = 0;

   logic [2:0] vec_q [$];
   status_t    st_q  [$];

   always #5 clk = ~clk;

   function automatic logic z_model(input int m, input logic [2:0] v);
      case (m)
         M_ZERO:  return 1'b0;
         M_INV:   return ~mux2_ref(v[2], v[1], v[0]);
         default: return mux2_ref(v[2], v[1], v[0]);
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         z_v[i] = z_model(mode[i], {a_v[i], b_v[i], c_v[i]});
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mux_sweep_checker #(.SETTLE_CYCLES(S_TAB[g])) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start_v[g]),
         .a          (a_v[g]),
         .b          (b_v[g]),
         .c          (c_v[g]),
         .z          (z_v[g]),
         .busy       (busy_v[g]),
         .done       (done_v[g]),
         .pass       (pass_v[g]),
         .err_count  (err_v[g]),
         .fail_valid (fval_v[g]),
         .fail_vec   (fvec_v[g])
      );
   end

   task automatic test_reset();
      rst_n   = 1'b0;
      start_v = '0;
      #12;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({a_v[i], b_v[i], c_v[i], busy_v[i], done_v[i], pass_v[i], err_v[i], fval_v[i], fvec_v[i]} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d got abc=%b busy=%b done=%b pass=%b err=%0d fv=%b fvec=%0d want all 0",
                     i, {a_v[i], b_v[i], c_v[i]}, busy_v[i], done_v[i], pass_v[i], err_v[i], fval_v[i], fvec_v[i]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one full sweep on instance inst with mux behaviour m; optionally re-pulses start mid-sweep.
   task automatic test_sweep(input int inst, input int m, input bit repulse, input string name);
      int         s   = S_TAB[inst];
      int         h   = 0;
      status_t    st;
      status_t    exp_st;
      logic [2:0] v;
      logic [2:0] abc;

      mode[inst] = m;
      st.err  = '0;
      st.fv   = 1'b0;
      st.fvec = '0;
      for (int i = 0; i < NUM_VEC; i++) begin
         v = 3'(i);
         vec_q.push_back(v);
         if (z_model(m, v) !== mux2_ref(v[2], v[1], v[0])) begin
            if (!st.fv) st.fvec = v;
            st.fv  = 1'b1;
            st.err = st.err + 4'd1;
         end
      end
      st.pass = (st.err == 4'd0);
      st_q.push_back(st);

      @(negedge clk);
      start_v[inst] = 1'b1;
      @(posedge clk);
      #1;
      start_v[inst] = 1'b0;

      for (int cyc = 0; cyc <= 8 * s + 3; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
         end
         start_v[inst] = repulse && (cyc == 3 || cyc == 10);
         abc = {a_v[inst], b_v[inst], c_v[inst]};

         checks++;
         if (busy_v[inst] !== (cyc < 8 * s)) begin
            errors++;
            $display("FAIL %s busy cyc=%0d got %b want %b", name, cyc, busy_v[inst], (cyc < 8 * s));
         end
         checks++;
         if (done_v[inst] !== (cyc == 8 * s)) begin
            errors++;
            $display("FAIL %s done cyc=%0d got %b want %b", name, cyc, done_v[inst], (cyc == 8 * s));
         end

         if (cyc < 8 * s) begin
            checks++;
            if (abc !== vec_q[0]) begin
               errors++;
               $display("FAIL %s vector cyc=%0d got abc=%b want %b", name, cyc, abc, vec_q[0]);
            end
            checks++;
            if (pass_v[inst] !== 1'b0) begin
               errors++;
               $display("FAIL %s pass_during_run cyc=%0d got %b want 0", name, cyc, pass_v[inst]);
            end
            if (cyc == 0) begin
               checks++;
               if ({err_v[inst], fval_v[inst], fvec_v[inst]} !== 8'd0) begin
                  errors++;
                  $display("FAIL %s status_clear got err=%0d fv=%b fvec=%0d want 0 0 0",
                           name, err_v[inst], fval_v[inst], fvec_v[inst]);
               end
            end
            h++;
            if (h == s) begin
               void'(vec_q.pop_front());
               h = 0;
            end
         end else begin
            if (cyc == 8 * s) exp_st = st_q.pop_front();
            checks++;
            if (abc !== 3'b111) begin
               errors++;
               $display("FAIL %s abc_hold cyc=%0d got %b want 111", name, cyc, abc);
            end
            checks++;
            if (err_v[inst] !== exp_st.err || fval_v[inst] !== exp_st.fv ||
                fvec_v[inst] !== exp_st.fvec || pass_v[inst] !== exp_st.pass) begin
               errors++;
               $display("FAIL %s status cyc=%0d got err=%0d fv=%b fvec=%0d pass=%b want err=%0d fv=%b fvec=%0d pass=%b",
                        name, cyc, err_v[inst], fval_v[inst], fvec_v[inst], pass_v[inst],
                        exp_st.err, exp_st.fv, exp_st.fvec, exp_st.pass);
            end
         end
      end
      start_v[inst] = 1'b0;

      checks++;
      if (vec_q.size() != 0) begin
         errors++;
         $display("FAIL %s vectors_left got %0d want 0", name, vec_q.size());
         vec_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      mode[0] = M_GOLD;
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      #1;
      start_v[0] = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({a_v[0], b_v[0], c_v[0], busy_v[0], done_v[0], pass_v[0], err_v[0], fval_v[0], fvec_v[0]} !== 15'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got abc=%b busy=%b done=%b pass=%b err=%0d fv=%b fvec=%0d want all 0",
                  {a_v[0], b_v[0], c_v[0]}, busy_v[0], done_v[0], pass_v[0], err_v[0], fval_v[0], fvec_v[0]);
      end
      checks++;
      if (g_dut[0].u_dut.state_q !== IDLE) begin
         errors++;
         $display("FAIL reset_mid_state got %0d want %0d", g_dut[0].u_dut.state_q, IDLE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_sweep(0, M_GOLD, 1'b0, "post_reset_sweep");
   endtask

   initial begin
      test_reset();
      test_sweep(0, M_GOLD, 1'b0, "golden_s2");
      test_sweep(0, M_ZERO, 1'b0, "z_stuck0");
      test_sweep(0, M_INV,  1'b0, "z_inverted");
      test_sweep(0, M_GOLD, 1'b1, "restart_ignored");
      test_reset_mid();
      test_sweep(1, M_GOLD, 1'b0, "golden_s1");
      test_sweep(2, M_GOLD, 1'b0, "golden_s15");
      test_sweep(2, M_ZERO, 1'b0, "z_stuck0_s15");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
